// File: rtl/seg_scan_driver_if.sv
// Bus between the segment decoder side and the scan driver: packed patterns and
// controls in, multiplexed segment/anode pins and frame strobe out.
interface seg_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    logic [8*DIGITS-1:0] seg_in;
    logic                load;
    logic                enable;
    logic [2:0]          bright;
    logic [7:0]          seg_out;
    logic [DIGITS-1:0]   an_out;
    logic                frame_done;

    modport master (
        output seg_in, load, enable, bright,
        input  seg_out, an_out, frame_done
    );

    modport slave (
        input  seg_in, load, enable, bright,
        output seg_out, an_out, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: double-buffered patterns swapped at
// frame boundaries, PWM brightness, dead time at each slot start, frame strobe.
module seg_scan_driver #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DEAD     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_driver_if.slave  bus
);
    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned LW = 3 + CW + 1;
    localparam int unsigned PW = 8 * DIGITS;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [PW-1:0]     pending_q, pending_d;
    logic [PW-1:0]     active_q, active_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              frame_done_q, frame_done_d;

    logic              tick;
    logic              fb;
    logic              lit;
    logic [LW-1:0]     lit_lim;
    logic [LW-1:0]     cnt_ext;
    logic [7:0]        seg_sel;
    logic [DIGITS-1:0] an_sel;

    // Slot prescaler and digit index; disabled scanning parks at digit 0, cnt 0.
    always_comb begin
        tick  = bus.enable && (cnt_q == CW'(SCAN_DIV - 1));
        fb    = tick && (idx_q == IW'(DIGITS - 1));
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!bus.enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (tick) begin
            cnt_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Double buffer: pending follows load; active swaps only at the frame
    // boundary, taking seg_in directly when a load lands on that same cycle.
    always_comb begin
        pending_d    = bus.load ? bus.seg_in : pending_q;
        active_d     = active_q;
        if (fb) begin
            active_d = bus.load ? bus.seg_in : pending_q;
        end
        frame_done_d = fb;
    end

    // Lit window and digit select; the product is kept at full width before the shift.
    always_comb begin
        lit_lim = ((LW'(bus.bright) + LW'(1)) * LW'(SCAN_DIV)) >> 3;
        cnt_ext = LW'(cnt_q);
        lit     = bus.enable && (cnt_ext >= LW'(DEAD)) && (cnt_ext < lit_lim);
        seg_sel = 8'hFF;
        an_sel  = '1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                seg_sel   = active_q[8*k +: 8];
                an_sel[k] = 1'b0;
            end
        end
        seg_d = lit ? seg_sel : 8'hFF;
        an_d  = lit ? an_sel  : '1;
    end

    // State and registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= '1;
            active_q     <= '1;
            seg_q        <= 8'hFF;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.an_out     = an_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a position-based reference model pushes the
// expected pin state per cycle; a monitor pops and compares on every falling edge.
module tb_seg_scan_driver;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned SD     = 16;
    localparam int unsigned DEAD   = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_scan_driver_if #(.DIGITS(DIGITS)) bus();

    seg_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SD), .DEAD(DEAD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] an;
        logic       fd;
    } obs_t;

    obs_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: cycles since scanning (re)started give slot, digit and
    // offset directly; frames swap the shown word at the end of the last digit.
    int unsigned m_pos;
    logic [31:0] m_pending;
    logic [31:0] m_active;

    initial begin
        obs_t        e;
        int unsigned cnt, idx, lim, b;
        logic [3:0]  an;
        m_pos     = 0;
        m_pending = '1;
        m_active  = '1;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_pos     = 0;
                m_pending = '1;
                m_active  = '1;
                e         = '{seg: 8'hFF, an: 4'hF, fd: 1'b0};
            end else begin
                cnt  = m_pos % SD;
                idx  = (m_pos / SD) % DIGITS;
                b    = bus.bright;
                lim  = ((b + 1) * SD) / 8;
                e.fd = bus.enable && (cnt == SD - 1) && (idx == DIGITS - 1);
                if (bus.enable && cnt >= DEAD && cnt < lim) begin
                    an      = 4'hF;
                    an[idx] = 1'b0;
                    e.seg   = m_active[8*idx +: 8];
                    e.an    = an;
                end else begin
                    e.seg = 8'hFF;
                    e.an  = 4'hF;
                end
                if (e.fd) m_active = bus.load ? bus.seg_in : m_pending;
                if (bus.load) m_pending = bus.seg_in;
                m_pos = bus.enable ? m_pos + 1 : 0;
            end
            expq.push_back(e);
        end
    end

    // Monitor: compares pins against the oldest expectation, plus anode exclusivity.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if ({bus.seg_out, bus.an_out, bus.frame_done} !== e) begin
                    errors++;
                    $display("FAIL scan t=%0t got seg=%h an=%h fd=%b want seg=%h an=%h fd=%b",
                             $time, bus.seg_out, bus.an_out, bus.frame_done, e.seg, e.an, e.fd);
                end
            end
            checks++;
            if ($isunknown(bus.an_out) || $countones(~bus.an_out) > 1) begin
                errors++;
                $display("FAIL onehot t=%0t got an=%b want at most one low", $time, bus.an_out);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_word(input logic [31:0] w);
        bus.seg_in = w;
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    initial begin
        int unsigned cyc;
        logic        got;
        rst_n      = 1'b0;
        bus.seg_in = '1;
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        bus.bright = 3'd7;
        cycles(3);
        rst_n = 1'b1;

        // First frame after release: blank, frame_done 64 cycles after release.
        cyc = 0;
        got = 1'b0;
        while (cyc < 200 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.seg_in = 32'h92A4F9C0;
                bus.load   = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            if (bus.frame_done) got = 1'b1;
        end
        checks++;
        if (!got || cyc != 64) begin
            errors++;
            $display("FAIL first_frame_done got %0d cycles (seen=%b) want 64", cyc, got);
        end

        // Full bright scan of the loaded word.
        cycles(64);
        // Load mid-frame at digit 1: old word persists until the frame boundary.
        cycles(20);
        load_word(32'h1188_2244);
        // Load exactly on the next frame boundary (posedge 192 after release).
        cycles(42);
        load_word(32'h0F1E_2D3C);
        cycles(70);

        // Brightness levels.
        bus.bright = 3'd0;
        cycles(64);
        bus.bright = 3'd3;
        cycles(64);
        bus.bright = 3'd7;

        // Enable drop mid-slot, load while disabled, re-enable.
        cycles(5);
        bus.enable = 1'b0;
        cycles(10);
        load_word(32'h5566_7788);
        cycles(10);
        bus.enable = 1'b1;
        cycles(140);

        // Asynchronous reset mid-scan inside a lit window.
        cycles(40);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.seg_out !== 8'hFF || bus.an_out !== 4'hF) begin
            errors++;
            $display("FAIL async_reset got seg=%h an=%h want seg=ff an=f", bus.seg_out, bus.an_out);
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(80);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            bus.load = 1'b0;
            if ($urandom_range(15) == 0) begin
                bus.seg_in = $urandom;
                bus.load   = 1'b1;
            end
            if ($urandom_range(49) == 0) bus.bright = 3'($urandom_range(7));
            if ($urandom_range(149) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(699) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        cycles(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
